// File: rtl/bt656_block_capture.sv
// BT.656 active-video capture into a ring of RAM banks, one block per LINES_PER_BLK lines.
// The DSP returns each completed bank with blk_ack; a full ring drops whole blocks.
module bt656_block_capture #(
    parameter int DW            = 8,
    parameter int ACTIVE_PIX    = 720,
    parameter int LINES_PER_BLK = 24,
    parameter int NBANKS        = 2,
    parameter int BANK_WORDS    = 20480,
    parameter int AW            = 16
) (
    input  logic                      llck,
    input  logic                      reset,
    input  logic [DW-1:0]             vpo,
    input  logic                      capture,
    input  logic [1:0]                mode,
    input  logic [1:0]                field_sel,
    input  logic                      blk_ack,
    output logic                      ram_we,
    output logic [AW-1:0]             ram_addr,
    output logic [DW-1:0]             ram_data,
    output logic                      blk_irq,
    output logic [$clog2(NBANKS)-1:0] bank_id,
    output logic                      field_irq,
    output logic                      error,
    output logic                      overrun
);
    // state  | meaning
    // IDLE   | capture off, waiting for capture = 1
    // HUNT   | waiting for an SAV of a selected field; watches EAVs for field end
    // ACTIVE | inside an active line, writing samples, then checking the EAV
    // ERROR  | stream violation; writes blocked until a capture rising edge
    localparam int LINE_BYTES = 2 * ACTIVE_PIX;
    localparam int BCW        = $clog2(LINE_BYTES + 4);
    localparam int LCW        = $clog2(LINES_PER_BLK + 1);
    localparam int PW         = $clog2(NBANKS + 1);
    localparam int BKW        = $clog2(NBANKS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0][7:0] hist_q, hist_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [LCW-1:0]  line_cnt_q, line_cnt_d;
    logic [AW-1:0]   word_cnt_q, word_cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic [BKW-1:0]  bank_q, bank_d;
    logic [PW-1:0]   pending_q, pending_d;
    logic            in_field_q, in_field_d;
    logic            suppress_q, suppress_d;
    logic            cap_q, cap_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_data_q, ram_data_d;
    logic            blk_irq_q, blk_irq_d;
    logic [BKW-1:0]  bank_id_q, bank_id_d;
    logic            field_irq_q, field_irq_d;
    logic            error_q, error_d;
    logic            overrun_q, overrun_d;

    logic [7:0] top8;
    logic       trs, f_bit, v_bit, h_bit, prot, wr_phase, go_err, pend_dec;

    always_comb begin
        top8     = vpo[DW-1 -: 8];
        trs      = (hist_q[2] == 8'hFF) && (hist_q[1] == 8'h00) && (hist_q[0] == 8'h00);
        f_bit    = top8[6];
        v_bit    = top8[5];
        h_bit    = top8[4];
        prot     = (top8 == 8'hFF) || (top8 == 8'h00);
        // byte phase 0 Cb, 1 Y, 2 Cr, 3 Y
        case (mode)
            2'b01:   wr_phase = ~byte_cnt_q[0];
            2'b10:   wr_phase = 1'b1;
            default: wr_phase = byte_cnt_q[0];
        endcase

        state_d     = state_q;
        hist_d      = {hist_q[1:0], top8};
        byte_cnt_d  = byte_cnt_q;
        line_cnt_d  = line_cnt_q;
        word_cnt_d  = word_cnt_q;
        base_d      = base_q;
        bank_d      = bank_q;
        pending_d   = pending_q;
        in_field_d  = in_field_q;
        suppress_d  = suppress_q;
        cap_d       = capture;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        blk_irq_d   = 1'b0;
        bank_id_d   = bank_id_q;
        field_irq_d = 1'b0;
        error_d     = error_q;
        overrun_d   = overrun_q;
        go_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    line_cnt_d = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    in_field_d = 1'b0;
                    suppress_d = 1'b0;
                    state_d    = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (trs && !h_bit && !v_bit && field_sel[f_bit]) begin
                    state_d    = ST_ACTIVE;
                    byte_cnt_d = '0;
                    in_field_d = 1'b1;
                    if (line_cnt_q == '0 && pending_q == PW'(NBANKS)) begin
                        suppress_d = 1'b1;
                        overrun_d  = 1'b1;
                    end
                end else if (trs && h_bit && v_bit && in_field_q) begin
                    // first blanking EAV after captured lines: drop any partial block
                    field_irq_d = 1'b1;
                    in_field_d  = 1'b0;
                    line_cnt_d  = '0;
                    word_cnt_d  = '0;
                    suppress_d  = 1'b0;
                    if (!capture) state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                if (byte_cnt_q < BCW'(LINE_BYTES)) begin
                    if (prot) begin
                        go_err = 1'b1;
                    end else if (wr_phase && !suppress_q) begin
                        ram_we_d   = 1'b1;
                        ram_data_d = vpo;
                        ram_addr_d = base_q + word_cnt_q;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else if (byte_cnt_q == BCW'(LINE_BYTES)) begin
                    if (top8 != 8'hFF) go_err = 1'b1;
                end else if (byte_cnt_q != BCW'(LINE_BYTES + 3)) begin
                    if (top8 != 8'h00) go_err = 1'b1;
                end else if (!h_bit) begin
                    go_err = 1'b1;
                end else begin
                    state_d = ST_HUNT;
                    if (line_cnt_q == LCW'(LINES_PER_BLK - 1)) begin
                        line_cnt_d = '0;
                        word_cnt_d = '0;
                        suppress_d = 1'b0;
                        if (!suppress_q) begin
                            blk_irq_d = 1'b1;
                            bank_id_d = bank_q;
                            if (bank_q == BKW'(NBANKS - 1)) begin
                                bank_d = '0;
                                base_d = '0;
                            end else begin
                                bank_d = bank_q + 1'b1;
                                base_d = base_q + AW'(BANK_WORDS);
                            end
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (capture && !cap_q) begin
                    state_d   = ST_IDLE;
                    error_d   = 1'b0;
                    overrun_d = 1'b0;
                end
            end
        endcase

        if (go_err) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
        end

        // a completion is counted while blk_irq is visible so a coincident ack cancels it
        pend_dec = blk_ack && (pending_q != '0);
        if (blk_irq_q && !pend_dec)      pending_d = pending_q + 1'b1;
        else if (pend_dec && !blk_irq_q) pending_d = pending_q - 1'b1;
    end

    always_ff @(posedge llck or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hist_q      <= '0;
            byte_cnt_q  <= '0;
            line_cnt_q  <= '0;
            word_cnt_q  <= '0;
            base_q      <= '0;
            bank_q      <= '0;
            pending_q   <= '0;
            in_field_q  <= 1'b0;
            suppress_q  <= 1'b0;
            cap_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            blk_irq_q   <= 1'b0;
            bank_id_q   <= '0;
            field_irq_q <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            byte_cnt_q  <= byte_cnt_d;
            line_cnt_q  <= line_cnt_d;
            word_cnt_q  <= word_cnt_d;
            base_q      <= base_d;
            bank_q      <= bank_d;
            pending_q   <= pending_d;
            in_field_q  <= in_field_d;
            suppress_q  <= suppress_d;
            cap_q       <= cap_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            blk_irq_q   <= blk_irq_d;
            bank_id_q   <= bank_id_d;
            field_irq_q <= field_irq_d;
            error_q     <= error_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign blk_irq   = blk_irq_q;
    assign bank_id   = bank_id_q;
    assign field_irq = field_irq_q;
    assign error     = error_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_bt656_block_capture.sv
// Scoreboard bench for bt656_block_capture with a reduced frame geometry
// (16 pixels per line, 4 lines per block, 2 banks 100 words apart).
module tb_bt656_block_capture;
    localparam int DW  = 8;
    localparam int AP  = 16;
    localparam int LPB = 4;
    localparam int NB  = 2;
    localparam int BWD = 100;
    localparam int AW  = 16;
    localparam int LB  = 2 * AP;

    logic          llck = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] vpo = 8'h80;
    logic          capture = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [1:0]    field_sel = 2'b01;
    logic          blk_ack = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          blk_irq;
    logic [0:0]    bank_id;
    logic          field_irq;
    logic          error;
    logic          overrun;

    bt656_block_capture #(
        .DW(DW), .ACTIVE_PIX(AP), .LINES_PER_BLK(LPB),
        .NBANKS(NB), .BANK_WORDS(BWD), .AW(AW)
    ) dut (
        .llck(llck), .reset(reset), .vpo(vpo), .capture(capture), .mode(mode),
        .field_sel(field_sel), .blk_ack(blk_ack), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .blk_irq(blk_irq), .bank_id(bank_id), .field_irq(field_irq),
        .error(error), .overrun(overrun)
    );

    always #5 llck = ~llck;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t        exp_wq[$];
    logic [0:0] exp_iq[$];
    int         exp_field = 0;
    int         exp_base = 0;
    int         exp_word = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int seed, input int i);
        return 8'(32'h20 + ((seed * 7 + i) % 160));
    endfunction

    function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    // Cb Y Cr Y: luma takes odd bytes, chroma even bytes, both takes all
    function automatic bit phase_wr(input int i);
        case (mode)
            2'b01:   return (i % 2) == 0;
            2'b10:   return 1'b1;
            default: return (i % 2) == 1;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        vpo = b;
        @(negedge llck);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) send_byte((i % 2) ? 8'h10 : 8'h80);
    endtask

    task automatic send_trs(input bit f, input bit v, input bit h);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(xy(f, v, h));
    endtask

    task automatic send_line(input bit f, input int seed, input bit wr, input int bad_idx,
                             input bit ack_end);
        bit dead;
        dead = 1'b0;
        send_trs(f, 1'b0, 1'b0);
        for (int i = 0; i < LB; i++) begin
            logic [7:0] b;
            b = (i == bad_idx) ? 8'h00 : gen(seed, i);
            if (i == bad_idx) dead = 1'b1;
            if (wr && !dead && phase_wr(i)) begin
                exp_wq.push_back({AW'(exp_base + exp_word), b});
                exp_word++;
            end
            send_byte(b);
        end
        send_trs(f, 1'b0, 1'b1);
        if (ack_end) begin
            blk_ack = 1'b1;
            send_byte(8'h80);
            blk_ack = 1'b0;
        end
        blank(4);
    endtask

    task automatic ack_pulse();
        blk_ack = 1'b1;
        @(negedge llck);
        blk_ack = 1'b0;
        @(negedge llck);
    endtask

    initial begin
        forever begin
            @(negedge llck);
            if (ram_we) begin
                if (exp_wq.size() == 0) begin
                    chk("unexpected_write_addr", ram_addr, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wq.pop_front();
                    chk("write_addr_data", {ram_addr, ram_data}, e);
                end
            end
            if (blk_irq) begin
                if (exp_iq.size() == 0) chk("unexpected_blk_irq", 1, 0);
                else chk("blk_irq_bank_id", bank_id, exp_iq.pop_front());
            end
            if (field_irq) begin
                chk("field_irq_expected", exp_field > 0, 1);
                if (exp_field > 0) exp_field--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge llck);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_blk_irq", blk_irq, 0);
        chk("rst_bank_id", bank_id, 0);
        chk("rst_field_irq", field_irq, 0);
        chk("rst_error", error, 0);
        chk("rst_overrun", overrun, 0);

        reset = 1'b1;
        capture = 1'b1;
        blank(6);

        // block 1: bank 0, addresses 0..63
        exp_base = 0; exp_word = 0;
        for (int l = 0; l < LPB; l++) begin
            if (l == LPB - 1) exp_iq.push_back(1'b0);
            send_line(1'b0, l, 1'b1, -1, 1'b0);
        end
        chk("pending_after_blk1", dut.pending_q, 1);
        exp_base = BWD; exp_word = 0;

        send_line(1'b1, 9, 1'b0, -1, 1'b0);

        // block 2: bank 1 starts at BANK_WORDS
        for (int l = 0; l < LPB; l++) begin
            if (l == LPB - 1) exp_iq.push_back(1'b1);
            send_line(1'b0, 10 + l, 1'b1, -1, 1'b0);
        end
        chk("pending_after_blk2", dut.pending_q, 2);
        chk("overrun_before_blk3", overrun, 0);
        exp_base = 0; exp_word = 0;

        // block 3: ring full, whole block dropped
        for (int l = 0; l < LPB; l++) begin
            send_line(1'b0, 20 + l, 1'b0, -1, 1'b0);
            if (l == 0) chk("overrun_at_blk3", overrun, 1);
        end
        chk("pending_after_blk3", dut.pending_q, 2);

        ack_pulse();
        chk("pending_after_ack", dut.pending_q, 1);

        // block 4 reuses bank 0; ack coincides with blk_irq
        for (int l = 0; l < LPB; l++) begin
            if (l == LPB - 1) exp_iq.push_back(1'b0);
            send_line(1'b0, 30 + l, 1'b1, -1, l == LPB - 1);
        end
        chk("pending_same_cycle", dut.pending_q, 1);
        exp_base = BWD; exp_word = 0;
        ack_pulse();
        chk("pending_second_ack", dut.pending_q, 0);
        ack_pulse();
        chk("pending_ack_at_zero", dut.pending_q, 0);

        // partial block then field end
        send_line(1'b0, 40, 1'b1, -1, 1'b0);
        send_line(1'b0, 41, 1'b1, -1, 1'b0);
        exp_field++;
        send_trs(1'b0, 1'b1, 1'b1);
        blank(4);
        chk("field_irq_seen", exp_field, 0);
        exp_word = 0;

        mode = 2'b10;
        send_line(1'b0, 42, 1'b1, -1, 1'b0);

        // stream error at pixel 5
        mode = 2'b00;
        chk("overrun_still_set", overrun, 1);
        send_line(1'b0, 43, 1'b1, 10, 1'b0);
        chk("error_set", error, 1);
        chk("state_error", dut.state_q, 3);
        capture = 1'b0;
        blank(2);
        capture = 1'b1;
        @(negedge llck);
        chk("error_cleared", error, 0);
        chk("overrun_cleared", overrun, 0);
        chk("state_idle", dut.state_q, 0);
        blank(3);
        exp_word = 0;

        mode = 2'b01;
        send_line(1'b0, 50, 1'b1, -1, 1'b0);
        mode = 2'b11;
        send_line(1'b0, 51, 1'b1, -1, 1'b0);

        field_sel = 2'b00;
        mode = 2'b00;
        send_line(1'b0, 52, 1'b0, -1, 1'b0);
        send_line(1'b1, 53, 1'b0, -1, 1'b0);
        chk("state_hunt_no_field", dut.state_q, 1);

        // reset mid-line
        field_sel = 2'b01;
        send_trs(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (phase_wr(i)) begin
                exp_wq.push_back({AW'(exp_base + exp_word), gen(60, i)});
                exp_word++;
            end
            send_byte(gen(60, i));
        end
        reset = 1'b0;
        for (int i = 11; i < 15; i++) begin
            send_byte(gen(60, i));
            chk("rst_mid_no_we", ram_we, 0);
        end
        chk("rst_mid_addr", ram_addr, 0);
        chk("rst_mid_data", ram_data, 0);
        chk("rst_mid_state", dut.state_q, 0);
        chk("rst_mid_pending", dut.pending_q, 0);

        chk("writes_outstanding", exp_wq.size(), 0);
        chk("irqs_outstanding", exp_iq.size(), 0);
        chk("field_irqs_outstanding", exp_field, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bt656_block_capture.md
BT656_BLOCK_CAPTURE -- requirements
Module: bt656_block_capture

Interface
REQ-001 SHALL have parameter DW, default 8, video sample width (8 or 10).
REQ-002 SHALL have parameter ACTIVE_PIX, default 720, luma pixels per active line.
REQ-003 SHALL have parameter LINES_PER_BLK, default 24, captured lines per block.
REQ-004 SHALL have parameter NBANKS, default 2, number of RAM banks in the ring (2..8).
REQ-005 SHALL have parameter BANK_WORDS, default 20480, address stride between banks.
REQ-006 SHALL have parameter AW, default 16, RAM address width.
REQ-007 SHALL have port llck, input, 1, 27 MHz video clock; all logic on posedge.
REQ-008 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port vpo, input, DW, BT.656 byte stream.
REQ-010 SHALL have port capture, input, 1, level; enables capture.
REQ-011 SHALL have port mode, input, 2, 00 luma, 01 chroma, 10 both, 11 reserved (treated as luma).
REQ-012 SHALL have port field_sel, input, 2, bit0 captures field 0, bit1 captures field 1.
REQ-013 SHALL have port blk_ack, input, 1, one-cycle pulse: DSP has consumed the oldest bank.
REQ-014 SHALL have outputs ram_we (1), ram_addr (AW) and ram_data (DW), forming the RAM write port.
REQ-015 SHALL have outputs blk_irq (1, pulse), bank_id (log2 NBANKS, bank just completed), field_irq (1, pulse), error (1, sticky) and overrun (1, sticky).

Function
REQ-016 SHALL detect a timing reference as all-ones, 0, 0, XY on consecutive cycles, comparing only vpo[DW-1:DW-8]; XY bit6 = F, bit5 = V, bit4 = H.
REQ-017 SHALL implement the states IDLE, HUNT, ACTIVE and ERROR.
REQ-018 IDLE: when capture = 1, SHALL clear the counters and go to HUNT.
REQ-019 HUNT: on an SAV (H = 0, V = 0) with field F selected by field_sel, SHALL go to ACTIVE and clear the byte phase; any other code stays in HUNT.
REQ-020 ACTIVE: byte phases cycle Cb, Y, Cr, Y.
REQ-021 ACTIVE writes: in luma mode SHALL write both Y phases; in chroma mode, both C phases; in both mode, every byte.
REQ-022 Write latency SHALL be 1 cycle: ram_we, ram_data and ram_addr are registered; ram_we is high for exactly 1 cycle per written sample.
REQ-023 ram_addr SHALL equal bank*BANK_WORDS + word_cnt, truncated to AW bits; word_cnt resets at each block start.
REQ-024 In ACTIVE, a protected value (all-ones or 0) that does not begin an EAV SHALL cause the ERROR state.
REQ-025 An EAV arriving when the byte count is not 2*ACTIVE_PIX SHALL cause the ERROR state.
REQ-026 A valid EAV SHALL increment the line count and return to HUNT.
REQ-027 When the line count reaches LINES_PER_BLK, blk_irq SHALL pulse for 1 cycle together with the completed bank_id.
REQ-028 On block completion, the bank SHALL advance modulo NBANKS, and the line count and word_cnt SHALL reset.
REQ-029 pending SHALL increment on block completion and decrement on blk_ack; if both occur in the same cycle, pending is unchanged; blk_ack with pending = 0 SHALL be ignored.
REQ-030 If pending = NBANKS at a block start, SHALL set overrun and suppress ram_we for that entire block; the bank does not advance and no blk_irq is issued for it.
REQ-031 An EAV with V = 1 ending a captured field SHALL pulse field_irq for 1 cycle.
REQ-032 At that field end, a partial block SHALL be discarded: line count and word_cnt reset, bank unchanged.
REQ-033 If capture is 0 at a field end, SHALL go to IDLE; a mid-field capture deassert has no other effect.
REQ-034 In ERROR, SHALL hold ram_we = 0 and error = 1.
REQ-035 A capture rising edge in ERROR SHALL go to IDLE and clear error and overrun; the bank ring and pending are preserved.
REQ-036 With field_sel = 00, SHALL remain in HUNT and never write.

Reset
REQ-037 While reset = 0, SHALL force state IDLE and set every output to 0, including ram_addr, ram_data and bank_id.
REQ-038 While reset = 0, SHALL set bank, pending, line count, word_cnt and byte phase to 0.
REQ-039 A reset asserted mid-line SHALL abort immediately, with no further ram_we.

Verification
REQ-040 Luma mode, DW = 8, ACTIVE_PIX = 720, 24 field-0 lines -> 17280 writes at addresses 0..17279, then one blk_irq with bank_id = 0; the next write goes to 20480.
REQ-041 Both mode, 1 line -> 1440 writes, ram_data sequence equal to the input Cb Y Cr Y order.
REQ-042 NBANKS = 2, no blk_ack, 3 blocks -> blk_irq twice; overrun = 1 at the third block start; zero writes during the third block.
REQ-043 Same-cycle blk_irq and blk_ack with pending = 1 -> pending stays 1; a subsequent ack brings it to 0.
REQ-044 A byte 00 at active pixel 100 -> ERROR, error = 1, no further writes; capture rising -> error = 0, state IDLE.
REQ-045 A field-0 end after 10 lines (LINES_PER_BLK = 24) -> field_irq pulse, no blk_irq; the next block starts at the same bank base.
